// File: rtl/key_debounce_longpress.sv
// N-channel active-low pushbutton conditioner: 2-flop sync, debounce, short/long
// classification and auto-repeat, all timed by a shared 1 ms tick.
module key_debounce_longpress #(
  parameter int unsigned N_KEYS      = 3,
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200,
  parameter bit          REPEAT_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_short,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int unsigned TICK_DIV   = CLK_FREQ_HZ / 1000;
  localparam int unsigned PW         = $clog2(TICK_DIV);
  localparam int unsigned HOLD_TICKS = LONG_MS - DEBOUNCE_MS;
  localparam int unsigned DW         = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned HW         = $clog2(HOLD_TICKS + 1);
  localparam int unsigned RW         = $clog2(REPEAT_MS + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DB_PRESS, ST_HELD, ST_LONG, ST_DB_REL
  } state_e;

  logic [PW-1:0]     pre_q;
  logic              tick_c;
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;

  assign tick_c = (pre_q == PW'(TICK_DIV - 1));

  // Shared 1 ms prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pre_q <= '0;
    else if (tick_c) pre_q <= '0;
    else             pre_q <= pre_q + PW'(1);
  end

  // Two-flop synchroniser, idles released (high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    state_e        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          long_flag_q, long_flag_d;
    logic          level_d, press_d, release_d, short_d, long_d, repeat_d;
    logic          level_q, press_q, release_q, short_q, long_q, repeat_q;
    logic          rel_c;

    // Synchronised key, 1 = released
    assign rel_c = sync2_q[k];

    always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      hcnt_d      = hcnt_q;
      rcnt_d      = rcnt_q;
      long_flag_d = long_flag_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      short_d     = 1'b0;
      long_d      = 1'b0;
      repeat_d    = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!rel_c) begin
            state_d = ST_DB_PRESS;
            dcnt_d  = '0;
          end
        end
        ST_DB_PRESS: begin
          if (rel_c) begin
            state_d = ST_IDLE;
          end else if (tick_c) begin
            if (dcnt_q == DW'(DEBOUNCE_MS - 1)) begin
              state_d     = ST_HELD;
              press_d     = 1'b1;
              hcnt_d      = '0;
              long_flag_d = 1'b0;
            end else begin
              dcnt_d = dcnt_q + DW'(1);
            end
          end
        end
        ST_HELD: begin
          if (rel_c) begin
            state_d = ST_DB_REL;
            dcnt_d  = '0;
          end else if (tick_c) begin
            if (hcnt_q == HW'(HOLD_TICKS - 1)) begin
              state_d     = ST_LONG;
              long_d      = 1'b1;
              long_flag_d = 1'b1;
              rcnt_d      = '0;
            end else begin
              hcnt_d = hcnt_q + HW'(1);
            end
          end
        end
        ST_LONG: begin
          if (rel_c) begin
            state_d = ST_DB_REL;
            dcnt_d  = '0;
          end else if (tick_c && REPEAT_EN) begin
            if (rcnt_q == RW'(REPEAT_MS - 1)) begin
              repeat_d = 1'b1;
              rcnt_d   = '0;
            end else begin
              rcnt_d = rcnt_q + RW'(1);
            end
          end
        end
        ST_DB_REL: begin
          // A press during release debounce resumes the frozen hold/repeat timing
          if (!rel_c) begin
            state_d = long_flag_q ? ST_LONG : ST_HELD;
          end else if (tick_c) begin
            if (dcnt_q == DW'(DEBOUNCE_MS - 1)) begin
              state_d     = ST_IDLE;
              release_d   = 1'b1;
              short_d     = !long_flag_q;
              long_flag_d = 1'b0;
            end else begin
              dcnt_d = dcnt_q + DW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      level_d = (state_d == ST_HELD) || (state_d == ST_LONG) || (state_d == ST_DB_REL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= ST_IDLE;
        dcnt_q      <= '0;
        hcnt_q      <= '0;
        rcnt_q      <= '0;
        long_flag_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        short_q     <= 1'b0;
        long_q      <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        state_q     <= state_d;
        dcnt_q      <= dcnt_d;
        hcnt_q      <= hcnt_d;
        rcnt_q      <= rcnt_d;
        long_flag_q <= long_flag_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
        short_q     <= short_d;
        long_q      <= long_d;
        repeat_q    <= repeat_d;
      end
    end

    assign key_level[k]   = level_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_short[k]   = short_q;
    assign key_long[k]    = long_q;
    assign key_repeat[k]  = repeat_q;
  end

endmodule
